pd_tx_ctrl: RTL and testbench
=============================

PD_TX_CTRL -- requirements
Module: pd_tx_ctrl

Interface
REQ-001 The block SHALL have these parameters: N_SOP, default 3, number of SOP* channels (SOP, SOP', SOP''), each with an independent MessageIDCounter.
REQ-002 The block SHALL have parameter RETRY_W, default 3, width of the retry counter and of n_retry.
REQ-003 The block SHALL have parameter TMR_W, default 8, width of the CRCReceiveTimer.
REQ-004 The block SHALL have parameter CRC_TIMEOUT, default 100, CRCReceiveTimer load value in clk cycles; legal range 1..2^TMR_W-1.
REQ-005 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock; all logic on rising edge
  reset  in  1  synchronous, active-high
  tx_req  in  1  one-cycle transmit request
  tx_type  in  3  TRANSMIT SOP* code; valid when < N_SOP
  n_retry  in  RETRY_W  nRetryCount; sampled at tx_req acceptance
  phy_start  out  1  PassBytes: level, asserted in CONSTRUCT
  phy_sop  out  3  latched SOP* code, valid while busy
  phy_msgid  out  3  MessageID of latched channel, valid while busy
  phy_sent  in  1  PHY accepted the message
  phy_discard  in  1  PHY discarded message (bus not idle)
  rx_goodcrc  in  1  one-cycle GoodCRC received strobe
  rx_sop  in  3  SOP* code of received GoodCRC
  rx_msgid  in  3  MessageID of received GoodCRC
  msgid_clr  in  N_SOP  per-channel MessageIDCounter clear (soft reset)
  busy  out  1  high in any state other than IDLE
  alert_success  out  1  one-cycle pulse, transmission succeeded
  alert_failed  out  1  one-cycle pulse, transmission failed
  retry_cnt  out  RETRY_W  current retry count

Function
REQ-006 The FSM SHALL have states IDLE, CONSTRUCT, WAIT_RESP, CHECK_RETRY, SUCCESS, FAIL, one-hot encoded.
REQ-007 In IDLE, tx_req with tx_type < N_SOP SHALL latch tx_type and n_retry, clear retry_cnt, and go to CONSTRUCT next cycle.
REQ-008 In IDLE, tx_req with tx_type >= N_SOP SHALL go to FAIL without touching any MessageIDCounter.
REQ-009 tx_req outside IDLE SHALL be ignored (no queueing).
REQ-010 In CONSTRUCT, phy_start SHALL be 1; phy_sent goes to WAIT_RESP and loads the timer with CRC_TIMEOUT; phy_discard goes to CHECK_RETRY; phy_sent wins if both are asserted.
REQ-011 In WAIT_RESP the timer SHALL decrement once per cycle; on the cycle it reads 1 without a match the FSM goes to CHECK_RETRY, so the timeout occurs exactly CRC_TIMEOUT cycles after entry.
REQ-012 A match SHALL be rx_goodcrc & (rx_sop == phy_sop) & (rx_msgid == phy_msgid); a match goes to SUCCESS and wins over a simultaneous timeout.
REQ-013 A non-matching GoodCRC SHALL be ignored; the timer keeps running.
REQ-014 In CHECK_RETRY: if retry_cnt == latched n_retry, go to FAIL; else increment retry_cnt and go to CONSTRUCT; total attempts = n_retry+1.
REQ-015 SUCCESS and FAIL SHALL each last one cycle, pulse alert_success or alert_failed, and return to IDLE.
REQ-016 SUCCESS and FAIL, except an invalid-type FAIL, SHALL increment the latched channel's MessageIDCounter modulo 8 (7 wraps to 0).
REQ-017 msgid_clr[i] SHALL zero counter i next cycle and take priority over a same-cycle increment.
REQ-018 msgid_clr SHALL not change the FSM state; phy_msgid SHALL stay at the value latched at acceptance.

Reset
REQ-019 Reset SHALL force IDLE, all MessageIDCounters to 0, the timer and retry_cnt to 0, phy_sop and phy_msgid to 0, and all outputs low.
REQ-020 Reset mid-transfer SHALL abort the transfer with no alert pulse; reset wins over all other inputs.

Structure
REQ-021 Package pd_tx_pkg SHALL hold the state encoding, the SOP* codes (SOP=0, SOP'=1, SOP''=2) and the MessageID width constant (3).
REQ-022 The timer SHALL be sub-module pd_crc_rcv_timer: a loadable TMR_W down-counter with an expire flag.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  tx_type=0, phy_sent, matching GoodCRC (sop 0, id 0) at cycle 10 -> alert_success; counter[0]=1; counters 1,2 unchanged.
  n_retry=2, no GoodCRC -> 3 phy_start assertions, each WAIT_RESP exactly 100 cycles, then alert_failed; counter[0] increments.
  GoodCRC with rx_msgid wrong, then correct -> first ignored, second yields success.
  8 successes on SOP' -> counter[1] wraps 7->0; msgid_clr[1] coincident with increment -> counter[1]=0.
  tx_type=5 -> alert_failed next cycle plus one; no phy_start; no counter change.
  Reset during WAIT_RESP -> IDLE next cycle, no alert pulse, all counters 0.

Source files
------------

// File: rtl/pd_tx_pkg.sv
// Shared constants for the USB-PD protocol transmit controller.
package pd_tx_pkg;

    localparam int unsigned MSGID_W = 3;
    localparam int unsigned SOP_W   = 3;
    localparam int unsigned ST_W    = 6;

    // One-hot transmit FSM encoding
    localparam logic [ST_W-1:0] ST_IDLE        = 6'b000001;
    localparam logic [ST_W-1:0] ST_CONSTRUCT   = 6'b000010;
    localparam logic [ST_W-1:0] ST_WAIT_RESP   = 6'b000100;
    localparam logic [ST_W-1:0] ST_CHECK_RETRY = 6'b001000;
    localparam logic [ST_W-1:0] ST_SUCCESS     = 6'b010000;
    localparam logic [ST_W-1:0] ST_FAIL        = 6'b100000;

    // SOP* codes
    localparam logic [SOP_W-1:0] SOP_SOP    = 3'd0;
    localparam logic [SOP_W-1:0] SOP_PRIME  = 3'd1;
    localparam logic [SOP_W-1:0] SOP_DPRIME = 3'd2;

endpackage

// File: rtl/pd_crc_rcv_timer.sv
// CRCReceiveTimer: loadable down-counter; expire_c flags the last counted cycle.
module pd_crc_rcv_timer #(
    parameter int unsigned TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             run,
    output logic             expire_c
);

    logic [TMR_W-1:0] count;

    // Load has priority; otherwise count down while running, saturating at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    assign expire_c = (count == TMR_W'(1));

endmodule

// File: rtl/pd_tx_ctrl.sv
// USB-PD protocol-layer transmit controller: MessageID tracking, GoodCRC wait and retries.
module pd_tx_ctrl
    import pd_tx_pkg::*;
#(
    parameter int unsigned N_SOP       = 3,
    parameter int unsigned RETRY_W     = 3,
    parameter int unsigned TMR_W       = 8,
    parameter int unsigned CRC_TIMEOUT = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_req,
    input  logic [SOP_W-1:0]   tx_type,
    input  logic [RETRY_W-1:0] n_retry,
    output logic               phy_start,
    output logic [SOP_W-1:0]   phy_sop,
    output logic [MSGID_W-1:0] phy_msgid,
    input  logic               phy_sent,
    input  logic               phy_discard,
    input  logic               rx_goodcrc,
    input  logic [SOP_W-1:0]   rx_sop,
    input  logic [MSGID_W-1:0] rx_msgid,
    input  logic [N_SOP-1:0]   msgid_clr,
    output logic               busy,
    output logic               alert_success,
    output logic               alert_failed,
    output logic [RETRY_W-1:0] retry_cnt
);

    logic [ST_W-1:0]    state_q;
    logic [ST_W-1:0]    state_d;
    logic [RETRY_W-1:0] nretry_q;
    logic               inval_q;
    logic [MSGID_W-1:0] msgid_cnt [N_SOP];
    logic [MSGID_W-1:0] sel_msgid;
    logic               type_ok;
    logic               accept;
    logic               reject;
    logic               tmr_load;
    logic               tmr_expire;
    logic               retry_inc;
    logic               match;
    logic               bump;

    assign type_ok = (32'(tx_type) < N_SOP);
    assign match   = rx_goodcrc && (rx_sop == phy_sop) && (rx_msgid == phy_msgid);
    assign bump    = ((state_q == ST_SUCCESS) || (state_q == ST_FAIL)) && !inval_q;

    // Current MessageID of the channel being requested
    always_comb begin
        sel_msgid = '0;
        for (int unsigned i = 0; i < N_SOP; i++) begin
            if (tx_type == SOP_W'(i)) begin
                sel_msgid = msgid_cnt[i];
            end
        end
    end

    // Next-state and transition strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        tmr_load  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_req) begin
                    if (type_ok) begin
                        accept  = 1'b1;
                        state_d = ST_CONSTRUCT;
                    end else begin
                        reject  = 1'b1;
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_CONSTRUCT: begin
                if (phy_sent) begin
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT_RESP;
                end else if (phy_discard) begin
                    state_d = ST_CHECK_RETRY;
                end
            end
            ST_WAIT_RESP: begin
                if (match) begin
                    state_d = ST_SUCCESS;
                end else if (tmr_expire) begin
                    state_d = ST_CHECK_RETRY;
                end
            end
            ST_CHECK_RETRY: begin
                if (retry_cnt == nretry_q) begin
                    state_d = ST_FAIL;
                end else begin
                    retry_inc = 1'b1;
                    state_d   = ST_CONSTRUCT;
                end
            end
            ST_SUCCESS: state_d = ST_IDLE;
            ST_FAIL:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register, registered outputs and per-transfer latches
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy          <= 1'b0;
            phy_start     <= 1'b0;
            alert_success <= 1'b0;
            alert_failed  <= 1'b0;
            phy_sop       <= '0;
            phy_msgid     <= '0;
            nretry_q      <= '0;
            retry_cnt     <= '0;
            inval_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy          <= (state_d != ST_IDLE);
            phy_start     <= (state_d == ST_CONSTRUCT);
            alert_success <= (state_d == ST_SUCCESS);
            alert_failed  <= (state_d == ST_FAIL);
            if (accept) begin
                phy_sop   <= tx_type;
                phy_msgid <= sel_msgid;
                nretry_q  <= n_retry;
                retry_cnt <= '0;
                inval_q   <= 1'b0;
            end
            if (reject) begin
                inval_q <= 1'b1;
            end
            if (retry_inc) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
        end
    end

    // MessageIDCounters: clear beats the end-of-transfer increment
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SOP; i++) begin
                msgid_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_SOP; i++) begin
                if (msgid_clr[i]) begin
                    msgid_cnt[i] <= '0;
                end else if (bump && (phy_sop == SOP_W'(i))) begin
                    msgid_cnt[i] <= msgid_cnt[i] + MSGID_W'(1);
                end
            end
        end
    end

    pd_crc_rcv_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_W'(CRC_TIMEOUT)),
        .run      (state_q == ST_WAIT_RESP),
        .expire_c (tmr_expire)
    );

endmodule

// File: tb/tb_pd_tx_ctrl.sv
// Scoreboard bench for pd_tx_ctrl: planned transfers predict outcome, duration and MessageID.
`timescale 1ns/1ps
module tb_pd_tx_ctrl;

    localparam int unsigned N_SOP   = 3;
    localparam int unsigned RETRY_W = 3;
    localparam int unsigned TMR_W   = 8;
    localparam int          T       = 100;

    logic               clk = 1'b0;
    logic               reset;
    logic               tx_req;
    logic [2:0]         tx_type;
    logic [RETRY_W-1:0] n_retry;
    logic               phy_start;
    logic [2:0]         phy_sop;
    logic [2:0]         phy_msgid;
    logic               phy_sent;
    logic               phy_discard;
    logic               rx_goodcrc;
    logic [2:0]         rx_sop;
    logic [2:0]         rx_msgid;
    logic [N_SOP-1:0]   msgid_clr;
    logic               busy;
    logic               alert_success;
    logic               alert_failed;
    logic [RETRY_W-1:0] retry_cnt;

    pd_tx_ctrl #(
        .N_SOP       (N_SOP),
        .RETRY_W     (RETRY_W),
        .TMR_W       (TMR_W),
        .CRC_TIMEOUT (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_req        (tx_req),
        .tx_type       (tx_type),
        .n_retry       (n_retry),
        .phy_start     (phy_start),
        .phy_sop       (phy_sop),
        .phy_msgid     (phy_msgid),
        .phy_sent      (phy_sent),
        .phy_discard   (phy_discard),
        .rx_goodcrc    (rx_goodcrc),
        .rx_sop        (rx_sop),
        .rx_msgid      (rx_msgid),
        .msgid_clr     (msgid_clr),
        .busy          (busy),
        .alert_success (alert_success),
        .alert_failed  (alert_failed),
        .retry_cnt     (retry_cnt)
    );

    always #5 clk = ~clk;

    // kind: 1 = success, 2 = failed; -1 means "don't care"
    typedef struct {
        int kind;
        int busy_len;
        int starts;
        int sop;
        int msgid;
        int retry;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_m [N_SOP];

    // Per-attempt plan. act: 0 discard, 1 sent+timeout, 2 sent+bad GoodCRC+timeout, 3 sent+match
    int p_act [8];
    int p_c   [8];
    int p_m   [8];
    int p_nm  [8];
    bit p_both[8];

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!phy_start) begin
            step();
            n++;
            if (n > 400) begin
                check("phy_start_wait", 0, 1);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy) begin
            step();
            n++;
            if (n > 1000) begin
                check("busy_drop_wait", 0, 1);
                return;
            end
        end
    endtask

    task automatic drive_crc(input int s, input int id);
        rx_goodcrc = 1'b1;
        rx_sop     = 3'(s);
        rx_msgid   = 3'(id);
    endtask

    // Transfer as seen from the outside: predict, queue expectation, then play the PHY/partner side
    task automatic run_tx(input int ty, input int nr, input bit clr_end);
        exp_t e;
        int   msg;
        int   rem;
        bit   ok;
        msg = 0;
        if (ty >= int'(N_SOP)) begin
            e.kind = 2; e.busy_len = 1; e.starts = 0;
            e.sop = -1; e.msgid = -1; e.retry = -1;
        end else begin
            msg = cnt_m[ty];
            e.kind = 2; e.busy_len = 0; e.starts = 0;
            e.sop = ty; e.msgid = msg; e.retry = nr;
            for (int i = 0; i <= nr; i++) begin
                e.starts++;
                e.busy_len += p_c[i] + 1 + ((p_act[i] == 0) ? 0 : ((p_act[i] == 3) ? p_m[i] : T));
                if (p_act[i] == 3) begin
                    e.kind  = 1;
                    e.retry = i;
                    break;
                end
            end
            if (e.kind == 2) e.busy_len += 1;
            cnt_m[ty] = clr_end ? 0 : (msg + 1) % 8;
        end
        exp_q.push_back(e);

        tx_req  = 1'b1;
        tx_type = 3'(ty);
        n_retry = RETRY_W'(nr);
        step();
        tx_req = 1'b0;
        if (ty < int'(N_SOP)) begin
            for (int i = 0; i <= nr; i++) begin
                wait_start(ok);
                if (!ok) return;
                repeat (p_c[i] - 1) step();
                if (p_act[i] == 0) begin
                    phy_discard = 1'b1;
                end else begin
                    phy_sent    = 1'b1;
                    phy_discard = p_both[i];
                end
                // A request while busy must be ignored, as must a changed n_retry
                tx_req  = ($urandom_range(0, 3) == 0);
                tx_type = 3'($urandom_range(0, 2));
                n_retry = RETRY_W'($urandom_range(0, 7));
                step();
                phy_sent = 1'b0; phy_discard = 1'b0; tx_req = 1'b0;
                if (p_act[i] == 2 || (p_act[i] == 3 && p_nm[i] > 0)) begin
                    repeat (p_nm[i] - 1) step();
                    if ($urandom_range(0, 1) == 0) drive_crc((ty + 1) % 3, msg);
                    else drive_crc(ty, (msg + 1 + int'($urandom_range(0, 6))) % 8);
                    step();
                    rx_goodcrc = 1'b0;
                end
                if (p_act[i] == 3) begin
                    rem = (p_nm[i] > 0) ? (p_m[i] - p_nm[i] - 1) : (p_m[i] - 1);
                    repeat (rem) step();
                    drive_crc(ty, msg);
                    step();
                    rx_goodcrc = 1'b0;
                    if (clr_end) msgid_clr = N_SOP'(1 << ty);
                    step();
                    msgid_clr = '0;
                    break;
                end
            end
        end
        wait_idle();
        step();
    endtask

    task automatic plan_clear();
        for (int i = 0; i < 8; i++) begin
            p_act[i] = 1; p_c[i] = 1; p_m[i] = 1; p_nm[i] = 0; p_both[i] = 1'b0;
        end
    endtask

    task automatic plan_random(input int nr, input bit succeed);
        int k;
        k = succeed ? int'($urandom_range(0, nr)) : nr + 1;
        for (int i = 0; i <= nr; i++) begin
            p_c[i]    = int'($urandom_range(1, 3));
            p_nm[i]   = 0;
            p_both[i] = 1'b0;
            if (i == k) begin
                p_act[i] = 3;
                p_m[i]   = ($urandom_range(0, 3) == 0) ? T : int'($urandom_range(1, 40));
                if (p_m[i] > 1 && $urandom_range(0, 1) == 0) p_nm[i] = int'($urandom_range(1, p_m[i] - 1));
            end else begin
                case ($urandom_range(0, 3))
                    0, 1:    p_act[i] = 0;
                    2:       p_act[i] = 1;
                    default: begin p_act[i] = 2; p_nm[i] = int'($urandom_range(1, T)); end
                endcase
            end
            if (p_act[i] != 0) p_both[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic check_counters(input string name);
        for (int i = 0; i < int'(N_SOP); i++) begin
            check(name, int'(dut.msgid_cnt[i]), cnt_m[i]);
        end
    endtask

    // Monitor: measure each busy episode and compare it against the head of the scoreboard
    bit   tracking = 1'b0;
    bit   prev_start = 1'b0;
    bit   capd;
    bit   unstable;
    int   m_len, m_starts, m_ns, m_nf, m_sop, m_id, m_rc;
    exp_t got_e;

    always @(negedge clk) begin
        if (reset) begin
            tracking   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (busy) begin
                if (!tracking) begin
                    tracking = 1'b1; m_len = 0; m_starts = 0; m_ns = 0; m_nf = 0;
                    capd = 1'b0; unstable = 1'b0; m_sop = -1; m_id = -1; m_rc = -1;
                end
                m_len++;
                if (phy_start && !prev_start) m_starts++;
                if (phy_start) begin
                    if (!capd) begin
                        capd = 1'b1; m_sop = int'(phy_sop); m_id = int'(phy_msgid);
                    end else if (m_sop != int'(phy_sop) || m_id != int'(phy_msgid)) begin
                        unstable = 1'b1;
                    end
                end
                if (alert_success) m_ns++;
                if (alert_failed) m_nf++;
                if (alert_success || alert_failed) m_rc = int'(retry_cnt);
            end else begin
                if (alert_success || alert_failed) check("alert_while_idle", 1, 0);
                if (tracking) begin
                    tracking = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_transfer", 1, 0);
                    end else begin
                        got_e = exp_q.pop_front();
                        check("alert_pulses", m_ns + m_nf, 1);
                        check("alert_kind", (m_ns > 0) ? 1 : 2, got_e.kind);
                        check("busy_cycles", m_len, got_e.busy_len);
                        check("phy_start_count", m_starts, got_e.starts);
                        check("sop_msgid_stable", int'(unstable), 0);
                        if (got_e.sop >= 0) begin
                            check("phy_sop", m_sop, got_e.sop);
                            check("phy_msgid", m_id, got_e.msgid);
                            check("retry_cnt_at_alert", m_rc, got_e.retry);
                        end
                    end
                end
            end
            prev_start = phy_start;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        reset = 1'b1; tx_req = 1'b0; tx_type = '0; n_retry = '0;
        phy_sent = 1'b0; phy_discard = 1'b0; rx_goodcrc = 1'b0;
        rx_sop = '0; rx_msgid = '0; msgid_clr = '0;
        for (int i = 0; i < int'(N_SOP); i++) cnt_m[i] = 0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_phy_start", int'(phy_start), 0);
        check("rst_alerts", int'(alert_success) + int'(alert_failed), 0);
        check("rst_retry_cnt", int'(retry_cnt), 0);
        check("rst_phy_sop", int'(phy_sop), 0);
        check("rst_phy_msgid", int'(phy_msgid), 0);
        check_counters("rst_counter");
        step();

        // SOP, sent, matching GoodCRC on cycle 10
        plan_clear(); p_act[0] = 3; p_c[0] = 1; p_m[0] = 9;
        run_tx(0, 0, 1'b0);
        check_counters("first_success_counter");

        // Two retries, all timing out
        plan_clear();
        run_tx(0, 2, 1'b0);
        check_counters("retry_fail_counter");

        // Wrong MessageID ignored, correct one accepted
        plan_clear(); p_act[0] = 3; p_nm[0] = 5; p_m[0] = 20;
        run_tx(0, 0, 1'b0);

        // Match on the very last timer cycle; discard followed by success; sent+discard together
        plan_clear(); p_act[0] = 3; p_m[0] = T;
        run_tx(2, 0, 1'b0);
        plan_clear(); p_act[0] = 0; p_c[0] = 2; p_act[1] = 3; p_m[1] = 3; p_both[1] = 1'b1;
        run_tx(2, 1, 1'b0);
        check_counters("sop_dprime_counter");

        // Eight SOP' successes wrap the counter, then a clear coinciding with the increment
        for (int n = 0; n < 8; n++) begin
            plan_clear(); p_act[0] = 3; p_m[0] = 2 + n;
            run_tx(1, 0, 1'b0);
        end
        check("sop_prime_wrap", int'(dut.msgid_cnt[1]), 0);
        plan_clear(); p_act[0] = 3; p_m[0] = 4;
        run_tx(1, 0, 1'b0);
        plan_clear(); p_act[0] = 3; p_m[0] = 4;
        run_tx(1, 0, 1'b1);
        check("clr_beats_increment", int'(dut.msgid_cnt[1]), cnt_m[1]);

        // Invalid SOP* code
        run_tx(5, 0, 1'b0);
        check_counters("invalid_type_counter");

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            int nr;
            int ty;
            nr = int'($urandom_range(0, 3));
            ty = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            plan_random(nr, $urandom_range(0, 2) != 0);
            run_tx(ty, nr, 1'b0);
        end
        check_counters("random_counter");
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset during WAIT_RESP aborts silently
        tx_req = 1'b1; tx_type = 3'd2; n_retry = 3'd3;
        step();
        tx_req = 1'b0;
        wait_start(ok);
        phy_sent = 1'b1;
        step();
        phy_sent = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        for (int i = 0; i < int'(N_SOP); i++) cnt_m[i] = 0;
        check("abort_busy", int'(busy), 0);
        check("abort_alerts", int'(alert_success) + int'(alert_failed), 0);
        check("abort_retry_cnt", int'(retry_cnt), 0);
        check_counters("abort_counter");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_abort_alerts", int'(alert_success) + int'(alert_failed) + int'(busy), 0);
            step();
        end

        // Fresh transfer after the abort starts from MessageID 0
        plan_clear(); p_act[0] = 3; p_m[0] = 6;
        run_tx(0, 0, 1'b0);
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
